// File: rtl/subservient_gpio_pkg.sv
// Shared definitions for the subservient GPIO bank.
// Register word addresses and byte-lane write helper.
package subservient_gpio_pkg;

  localparam logic [2:0] ADR_OUT = 3'd0;
  localparam logic [2:0] ADR_OE  = 3'd1;
  localparam logic [2:0] ADR_IN  = 3'd2;
  localparam logic [2:0] ADR_IE  = 3'd3;
  localparam logic [2:0] ADR_IP  = 3'd4;
  localparam logic [2:0] ADR_POL = 3'd5;

  // Replace only the byte lanes whose select bit is set.
  function automatic logic [31:0] byte_update(
    input logic [31:0] old,
    input logic [31:0] dat,
    input logic [3:0]  sel
  );
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) r[8*b +: 8] = dat[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/subservient_gpio_sync.sv
// Multi-stage input synchroniser for the GPIO pads.
// Flop chain only; edge detection lives in the bank.
module subservient_gpio_sync
  import subservient_gpio_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] chain_q [STAGES];

  // shift pad samples down the chain
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int s = 0; s < int'(STAGES); s++) chain_q[s] <= '0;
    end else begin
      chain_q[0] <= i_d;
      for (int s = 1; s < int'(STAGES); s++) chain_q[s] <= chain_q[s-1];
    end
  end

  assign o_q = chain_q[STAGES-1];

endmodule

// File: rtl/subservient_gpio_bank.sv
// WIDTH-bit GPIO bank on a Wishbone peripheral port with
// output enables, synchronised inputs and edge interrupts.
module subservient_gpio_bank
  import subservient_gpio_pkg::*;
#(
  parameter int unsigned      WIDTH       = 8,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] OUT_RST     = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [2:0]       i_wb_adr,
  input  logic [31:0]      i_wb_dat,
  input  logic [3:0]       i_wb_sel,
  input  logic             i_wb_we,
  input  logic             i_wb_stb,
  output logic [31:0]      o_wb_rdt,
  output logic             o_wb_ack,
  input  logic [WIDTH-1:0] i_gpio,
  output logic [WIDTH-1:0] o_gpio,
  output logic [WIDTH-1:0] o_gpio_oe,
  output logic             o_irq
);

  logic [WIDTH-1:0] out_q, oe_q, ie_q, ip_q, pol_q;
  logic [WIDTH-1:0] in_s, prev_q, edge_s, ip_clr;
  logic [31:0]      out_w, oe_w, ie_w, ip_w, pol_w, in_w;
  logic [31:0]      out_n, oe_n, ie_n, pol_n, clr_n;
  logic [31:0]      rd_data;
  logic             acc, wr;
  logic             unused_bits;

  subservient_gpio_sync #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_gpio),
    .o_q     (in_s)
  );

  assign acc = i_wb_stb & ~o_wb_ack;
  assign wr  = acc & i_wb_we;

  // zero-extend the registers onto the 32-bit bus
  always_comb begin
    out_w = '0;
    oe_w  = '0;
    ie_w  = '0;
    ip_w  = '0;
    pol_w = '0;
    in_w  = '0;
    out_w[WIDTH-1:0] = out_q;
    oe_w[WIDTH-1:0]  = oe_q;
    ie_w[WIDTH-1:0]  = ie_q;
    ip_w[WIDTH-1:0]  = ip_q;
    pol_w[WIDTH-1:0] = pol_q;
    in_w[WIDTH-1:0]  = in_s;
  end

  assign out_n = byte_update(out_w, i_wb_dat, i_wb_sel);
  assign oe_n  = byte_update(oe_w, i_wb_dat, i_wb_sel);
  assign ie_n  = byte_update(ie_w, i_wb_dat, i_wb_sel);
  assign pol_n = byte_update(pol_w, i_wb_dat, i_wb_sel);
  assign clr_n = byte_update('0, i_wb_dat, i_wb_sel);

  assign unused_bits = ^{out_n, oe_n, ie_n, pol_n, clr_n};

  // read multiplexer; unmapped words read as zero
  always_comb begin
    rd_data = '0;
    case (i_wb_adr)
      ADR_OUT: rd_data = out_w;
      ADR_OE:  rd_data = oe_w;
      ADR_IN:  rd_data = in_w;
      ADR_IE:  rd_data = ie_w;
      ADR_IP:  rd_data = ip_w;
      ADR_POL: rd_data = pol_w;
      default: rd_data = '0;
    endcase
  end

  assign edge_s = (pol_q & in_s & ~prev_q)
                | (~pol_q & ~in_s & prev_q);

  assign ip_clr = (wr && i_wb_adr == ADR_IP)
                ? clr_n[WIDTH-1:0] : '0;

  // single-cycle ack with read data captured on the same edge
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_wb_ack <= 1'b0;
      o_wb_rdt <= '0;
    end else begin
      o_wb_ack <= acc;
      if (acc) o_wb_rdt <= rd_data;
    end
  end

  // software-owned control registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_q <= OUT_RST;
      oe_q  <= '0;
      ie_q  <= '0;
      pol_q <= '0;
    end else if (wr) begin
      case (i_wb_adr)
        ADR_OUT: out_q <= out_n[WIDTH-1:0];
        ADR_OE:  oe_q  <= oe_n[WIDTH-1:0];
        ADR_IE:  ie_q  <= ie_n[WIDTH-1:0];
        ADR_POL: pol_q <= pol_n[WIDTH-1:0];
        default: ;
      endcase
    end
  end

  // edge history, pending flags (edge beats W1C) and irq
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prev_q <= '0;
      ip_q   <= '0;
      o_irq  <= 1'b0;
    end else begin
      prev_q <= in_s;
      ip_q   <= (ip_q & ~ip_clr) | edge_s;
      o_irq  <= |(ip_q & ie_q);
    end
  end

  assign o_gpio    = out_q;
  assign o_gpio_oe = oe_q;

endmodule
